// File: rtl/dm_arbiter_if.sv
// Requester, memory and status signals shared between the data-memory
// arbiter (slave side) and its environment: requesters plus memory (master side).
interface dm_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [31:0]       m0_pc4;
  logic              m0_ack;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_pc4;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_pc4,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m1_ack, rdata, busy,
    output mem_addr, mem_wdata, mem_we, mem_pc4
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_pc4,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m1_ack, rdata, busy,
    input  mem_addr, mem_wdata, mem_we, mem_pc4
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the
// CPU load/store stage (m0) and the debug/DMA port (m1).
module dm_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              last_q;
  logic              grant;
  logic              grant_id;

  logic              owner_p0;
  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [31:0]       pc4_p0;
  logic [DATA_W-1:0] rdata_p1;

  // In DONE only the other requester may be granted; the owner's req is
  // still high for this cycle and must not start a second access.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_id = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          grant    = 1'b1;
          grant_id = ~last_q;
        end else if (bus.m0_req) begin
          grant    = 1'b1;
          grant_id = 1'b0;
        end else if (bus.m1_req) begin
          grant    = 1'b1;
          grant_id = 1'b1;
        end
        if (grant) state_d = SERVE;
      end
      SERVE: state_d = DONE;
      DONE: begin
        grant    = owner_p0 ? bus.m0_req : bus.m1_req;
        grant_id = ~owner_p0;
        state_d  = grant ? SERVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grant stage: capture the winner's request fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q   <= 1'b1;
      owner_p0 <= 1'b0;
      we_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      pc4_p0   <= '0;
    end else if (grant) begin
      last_q   <= grant_id;
      owner_p0 <= grant_id;
      we_p0    <= grant_id ? bus.m1_we    : bus.m0_we;
      addr_p0  <= grant_id ? bus.m1_addr  : bus.m0_addr;
      wdata_p0 <= grant_id ? bus.m1_wdata : bus.m0_wdata;
      pc4_p0   <= grant_id ? 32'h0        : bus.m0_pc4;
    end
  end

  // Serve stage: capture read data, writes leave rdata untouched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_p1 <= '0;
    end else if (state_q == SERVE && !we_p0) begin
      rdata_p1 <= bus.mem_rdata;
    end
  end

  // State is cleared asynchronously, so mem_we falls as soon as reset asserts.
  assign bus.mem_we    = (state_q == SERVE) && we_p0;
  assign bus.mem_addr  = addr_p0;
  assign bus.mem_wdata = wdata_p0;
  assign bus.mem_pc4   = pc4_p0;
  assign bus.m0_ack    = (state_q == DONE) && !owner_p0;
  assign bus.m1_ack    = (state_q == DONE) &&  owner_p0;
  assign bus.rdata     = rdata_p1;
  assign bus.busy      = (state_q != IDLE);

  a_ack_onehot: assert property (@(posedge clk) disable iff (!reset)
    !(bus.m0_ack && bus.m1_ack));
  a_we_in_serve: assert property (@(posedge clk) disable iff (!reset)
    bus.mem_we |-> (state_q == SERVE));

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: requester drivers, a behavioural memory
// and a monitor that checks every SERVE and ack cycle against predictions.
module tb_dm_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          who;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pc4;
    logic [31:0] rdata;
    bit          chg;
    logic [9:0]  chg_addr;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  txn_t sb[$];
  txn_t mon_e;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] model_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_total = 0;
  int ack0_cyc = 0;
  int ack1_cyc = 0;
  int age0 = 0;
  int age1 = 0;
  bit ack0_seen = 1'b0;
  bit ack1_seen = 1'b0;

  // Behavioural data memory: synchronous write, combinational read
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  // Requester drivers: hold req until ack, then present the next queued item
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0.delete();
      age0 = 0;
      bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0;
      bus.m0_wdata = '0; bus.m0_pc4 = '0;
    end else begin
      if (ack0_seen && q0.size() > 0) begin
        q0.delete(0);
        age0 = 0;
      end else if (bus.m0_req) age0++;
      else age0 = 0;
      #1;
      if (q0.size() > 0) begin
        bus.m0_req   = 1'b1;
        bus.m0_we    = q0[0].we;
        bus.m0_addr  = (q0[0].chg && age0 >= 1) ? q0[0].chg_addr : q0[0].addr;
        bus.m0_wdata = q0[0].wdata;
        bus.m0_pc4   = q0[0].pc4;
      end else bus.m0_req = 1'b0;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1.delete();
      age1 = 0;
      bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    end else begin
      if (ack1_seen && q1.size() > 0) begin
        q1.delete(0);
        age1 = 0;
      end else if (bus.m1_req) age1++;
      else age1 = 0;
      #1;
      if (q1.size() > 0) begin
        bus.m1_req   = 1'b1;
        bus.m1_we    = q1[0].we;
        bus.m1_addr  = (q1[0].chg && age1 >= 1) ? q1[0].chg_addr : q1[0].addr;
        bus.m1_wdata = q1[0].wdata;
      end else bus.m1_req = 1'b0;
    end
  end

  // Monitor: SERVE cycles checked against the scoreboard head, acks pop it
  always @(negedge clk) begin
    ack0_seen = bus.m0_ack;
    ack1_seen = bus.m1_ack;
    if (reset) begin
      if (bus.m0_ack || bus.m1_ack) begin
        n_checks++;
        ack_total++;
        if (bus.m0_ack) ack0_cyc = cyc;
        else            ack1_cyc = cyc;
        if (bus.m0_ack && bus.m1_ack) begin
          n_fail++;
          $display("FAIL ack_onehot: m0_ack=%b m1_ack=%b, required at most one", bus.m0_ack, bus.m1_ack);
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: m0_ack=%b m1_ack=%b with nothing outstanding", bus.m0_ack, bus.m1_ack);
        end else begin
          mon_e = sb.pop_front();
          if (bus.m1_ack !== mon_e.who) begin
            n_fail++;
            $display("FAIL ack_owner: got m1_ack=%b, required owner %0d", bus.m1_ack, mon_e.who);
          end
          n_checks++;
          if (bus.rdata !== mon_e.rdata) begin
            n_fail++;
            $display("FAIL ack_rdata: got %h, required %h", bus.rdata, mon_e.rdata);
          end
        end
      end else if (bus.busy) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL serve_unexpected: busy with nothing outstanding");
        end else begin
          mon_e = sb[0];
          if ({bus.mem_we, bus.mem_addr, bus.mem_pc4} !== {mon_e.we, mon_e.addr, mon_e.pc4}) begin
            n_fail++;
            $display("FAIL serve_bus: got we=%b addr=%h pc4=%h, required we=%b addr=%h pc4=%h",
                     bus.mem_we, bus.mem_addr, bus.mem_pc4, mon_e.we, mon_e.addr, mon_e.pc4);
          end
          if (mon_e.we) begin
            n_checks++;
            if (bus.mem_wdata !== mon_e.wdata) begin
              n_fail++;
              $display("FAIL serve_wdata: got %h, required %h", bus.mem_wdata, mon_e.wdata);
            end
          end
        end
      end else begin
        n_checks++;
        if (bus.mem_we !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_mem_we: got %b, required 0", bus.mem_we);
        end
      end
    end
  end

  task automatic push_txn(input bit who, input logic we, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc4,
                          input bit commit, input bit chg, input logic [9:0] chg_addr);
    txn_t t;
    t.who = who; t.we = we; t.addr = addr; t.wdata = wdata;
    t.pc4 = who ? 32'h0 : pc4;
    t.chg = chg; t.chg_addr = chg_addr;
    if (we) begin
      if (commit) ref_mem[addr] = wdata;
    end else model_rdata = ref_mem[addr];
    t.rdata = model_rdata;
    sb.push_back(t);
    if (who) q1.push_back(t);
    else     q0.push_back(t);
  endtask

  task automatic drain(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
    end
    if (i == budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d items outstanding after %0d cycles, required 0", name, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.mem_we, bus.m0_ack, bus.m1_ack} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/we/ack0/ack1=%b, required 0000",
               {bus.busy, bus.mem_we, bus.m0_ack, bus.m1_ack});
    end
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h, required 0", bus.rdata);
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_pc4, bus.mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_latched: addr=%h pc4=%h wdata=%h, required 0", bus.mem_addr, bus.mem_pc4, bus.mem_wdata);
    end
    reset = 1'b1;
  endtask

  task automatic test_single_write();
    int k;
    @(negedge clk);
    k = cyc;
    push_txn(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 32'h3004, 1'b1, 1'b0, 10'h0);
    drain(20, "single_write");
    n_checks++;
    if (ack0_cyc != k + 3) begin
      n_fail++;
      $display("FAIL write_latency: ack at cycle %0d, required %0d", ack0_cyc, k + 3);
    end
    n_checks++;
    if (mem[5] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_mem5: got %h, required deadbeef", mem[5]);
    end
  endtask

  task automatic test_read_back();
    @(negedge clk);
    push_txn(1'b1, 1'b0, 10'h005, 32'h0, 32'h0, 1'b1, 1'b0, 10'h0);
    drain(20, "read_back");
    n_checks++;
    if (bus.rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL readback_hold: rdata %h, required deadbeef", bus.rdata);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    apply_reset();
    @(negedge clk);
    k = cyc;
    push_txn(1'b0, 1'b1, 10'h001, 32'h1, 32'h3100, 1'b1, 1'b0, 10'h0);
    push_txn(1'b1, 1'b1, 10'h002, 32'h2, 32'h0, 1'b1, 1'b0, 10'h0);
    push_txn(1'b0, 1'b0, 10'h002, 32'h0, 32'h3104, 1'b1, 1'b0, 10'h0);
    push_txn(1'b1, 1'b0, 10'h001, 32'h0, 32'h0, 1'b1, 1'b0, 10'h0);
    push_txn(1'b0, 1'b1, 10'h3FF, 32'hA5A5A5A5, 32'h3108, 1'b1, 1'b0, 10'h0);
    push_txn(1'b1, 1'b0, 10'h3FF, 32'h0, 32'h0, 1'b1, 1'b0, 10'h0);
    drain(60, "back_to_back");
    n_checks++;
    if (ack0_cyc != k + 11 || ack1_cyc != k + 13) begin
      n_fail++;
      $display("FAIL b2b_rate: last acks at %0d/%0d, required %0d/%0d", ack0_cyc, ack1_cyc, k + 11, k + 13);
    end
    n_checks++;
    if ({mem[1], mem[2], mem[1023]} !== {32'h1, 32'h2, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL b2b_mem: words %h %h %h, required 1 2 a5a5a5a5", mem[1], mem[2], mem[1023]);
    end
  endtask

  task automatic test_field_change();
    @(negedge clk);
    push_txn(1'b1, 1'b1, 10'h009, 32'h99, 32'h0, 1'b1, 1'b0, 10'h0);
    drain(20, "seed9");
    push_txn(1'b0, 1'b1, 10'h007, 32'h77, 32'h3008, 1'b1, 1'b1, 10'h009);
    drain(20, "field_change");
    n_checks++;
    if ({mem[7], mem[9]} !== {32'h77, 32'h99}) begin
      n_fail++;
      $display("FAIL field_change: word7=%h word9=%h, required 77 99", mem[7], mem[9]);
    end
  endtask

  task automatic test_reset_mid_serve();
    int i;
    int acks_before;
    @(negedge clk);
    push_txn(1'b1, 1'b1, 10'h003, 32'h33333333, 32'h0, 1'b1, 1'b0, 10'h0);
    drain(20, "seed3");
    push_txn(1'b0, 1'b1, 10'h003, 32'hBAD0BAD0, 32'h4000, 1'b0, 1'b0, 10'h0);
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy && !bus.m0_ack && !bus.m1_ack) break;
    end
    n_checks++;
    if (bus.mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_serve_we: mem_we %b before reset, required 1", bus.mem_we);
    end
    acks_before = ack_total;
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_we, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_async: mem_we/busy=%b during reset, required 00", {bus.mem_we, bus.busy});
    end
    #1 reset = 1'b1;
    sb.delete();
    model_rdata = '0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (ack_total != acks_before) begin
      n_fail++;
      $display("FAIL abort_no_ack: %0d acks after abort, required 0", ack_total - acks_before);
    end
    n_checks++;
    if (mem[3] !== 32'h33333333 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_mem3: word3=%h busy=%b, required 33333333 0", mem[3], bus.busy);
    end
    push_txn(1'b0, 1'b0, 10'h003, 32'h0, 32'h4004, 1'b1, 1'b0, 10'h0);
    drain(20, "after_abort");
    n_checks++;
    if (bus.rdata !== 32'h33333333) begin
      n_fail++;
      $display("FAIL after_abort_read: rdata %h, required 33333333", bus.rdata);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.mem_we, bus.m0_ack, bus.m1_ack} !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_%0d: busy/we/ack0/ack1=%b, required 0000", i,
                 {bus.busy, bus.mem_we, bus.m0_ack, bus.m1_ack});
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    model_rdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_single_write();
    test_read_back();
    test_back_to_back();
    test_field_change();
    test_reset_mid_serve();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port, word-addressed data memory (1024 x 32, synchronous write, combinational read) between two requesters: m0 (CPU load/store stage) and m1 (debug/DMA port).
- Uses a round-robin grant and a req/ack handshake.
- Latches each request, drives the memory for exactly one cycle, registers the read data, and returns a one-cycle ack.
- Sits between the requesters and the data memory; the memory's own write enable is driven only from this block.

Parameters:
- ADDR_W, 10, word-address width (memory depth 2^ADDR_W).
- DATA_W, 32, data width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- m0_req  input  1  m0 request; held high until m0_ack is seen.
- m0_we  input  1  m0 write (1) / read (0).
- m0_addr  input  ADDR_W  m0 word address.
- m0_wdata  input  DATA_W  m0 write data.
- m0_pc4  input  32  PC+4 of the m0 instruction, forwarded for the memory's write log.
- m0_ack  output  1  one-cycle completion pulse for m0.
- m1_req  input  1  m1 request.
- m1_we  input  1  m1 write/read.
- m1_addr  input  ADDR_W  m1 word address.
- m1_wdata  input  DATA_W  m1 write data.
- m1_ack  output  1  one-cycle completion pulse for m1.
- rdata  output  DATA_W  registered read data; valid in the ack cycle.
- mem_addr  output  ADDR_W  to memory address.
- mem_wdata  output  DATA_W  to memory write data.
- mem_we  output  1  to memory write enable.
- mem_pc4  output  32  to memory PC+4 (0 when m1 owns the access).
- mem_rdata  input  DATA_W  from memory combinational read data.
- busy  output  1  high in SERVE and DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last=1 (so m0 wins the first tie).
  - Latched addr/wdata/we/pc4/owner cleared.
  - rdata=0, m0_ack=m1_ack=0, busy=0.
  - mem_we=0 immediately, without waiting for a clock edge.
- States: IDLE, SERVE, DONE.
- IDLE:
  - No request: stay.
  - Exactly one req: grant it.
  - Both req: grant the requester != last.
  - On the grant edge: latch that requester's we/addr/wdata, and pc4 (m0 only, else 0); set owner and last=owner; go to SERVE.
- SERVE (exactly 1 cycle):
  - mem_addr/mem_wdata/mem_pc4 come from the latched values.
  - mem_we = latched we, asserted only in this state.
  - On the edge: rdata <= mem_rdata for a read; rdata keeps its previous value for a write. Assert the owner's ack and go to DONE.
- DONE (exactly 1 cycle):
  - Owner's ack=1, rdata valid; the requester drops req on the following edge.
  - The owner's req is ignored in DONE.
  - If the other requester's req=1: grant it directly (latch, go to SERVE).
  - Otherwise go to IDLE.
- Outside SERVE: mem_we=0; mem_addr/mem_wdata/mem_pc4 hold the latched values (don't-care to the memory).
- Latency:
  - Request in IDLE: ack 2 cycles after the first edge that samples req.
  - Back-to-back contention: one access every 2 cycles, strictly alternating.
- Requester fields may change after the grant edge without effect.
- A req dropped before grant is simply never served; no ack.
- Reset asserted during SERVE: the write is aborted (mem_we falls combinationally before the edge); no ack is issued.
- Addresses are word indices; no byte-lane handling; no wrap logic (the address is passed through unchanged, full ADDR_W range).
- Exactly one of m0_ack/m1_ack may be high in any cycle; ack is never high outside DONE.

Test Plan:
- Reset then single write: m0_req=1, we=1, addr=10'h005, wdata=32'hDEADBEEF, pc4=32'h3004 → the next cycle is SERVE with mem_we=1, mem_addr=5, mem_pc4=32'h3004; m0_ack=1 the cycle after; memory word 5 = DEADBEEF.
- Read-back: m1_req=1, we=0, addr=5 → m1_ack pulse with rdata=32'hDEADBEEF; mem_we stays 0 and mem_pc4=0 throughout.
- Simultaneous after reset: m0 writes 32'h1 to addr 1 and m1 writes 32'h2 to addr 2 in the same cycle → m0 is served first, then m1 (SERVE at cycles 1 and 3, acks at cycles 2 and 4); continuous dual requests alternate m0, m1, m0, m1.
- Field change after grant: m0 changes addr from 7 to 9 one cycle after the grant edge → the memory still sees addr 7; word 9 is untouched.
- Async reset mid-SERVE: reset=0 pulse inside the SERVE cycle of a write to addr 3 → mem_we drops immediately, word 3 is unchanged, no ack, state=IDLE; the next request is served normally.
- Idle stability: no req for 20 cycles → busy=0, mem_we=0, both acks 0.
